// File: rtl/line_lane_stream_pipe_pkg.sv
// Shared types and sizing helpers for the line/beat streaming engine.
//   t_state     : run controller states
//   LINE_W_DEF  : default cache line width
//   beat_idx_w  : width of a beat index for a given beats-per-line
//   credit_w    : width of the issue credit counter
package stream_pipe_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} t_state;

  localparam int LINE_W_DEF = 512;

  function automatic int beat_idx_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  // Must hold the full initial credit value, hence the +1.
  function automatic int credit_w(input int lines, input int beats);
    return $clog2(lines * beats + 1);
  endfunction

endpackage

// File: rtl/line_sync_fifo.sv
// Synchronous line FIFO.
//   clk, reset      : clock, async active-high reset
//   push, wdata     : write side
//   pop, rdata      : read side; rdata is the head entry
//   full, empty     : occupancy flags
// A push while full is accepted only together with a pop.
module line_sync_fifo #(
  parameter int W     = 512,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW:0]             wptr, rptr;
  logic                    do_push, do_pop;

  // Extra pointer bit separates full from empty when the indexes match.
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem  <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) begin
        mem[wptr[AW-1:0]] <= wdata;
        wptr              <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/line_lane_stream_pipe.sv
// Line -> beat -> external compute pipe -> line streaming engine.
//   clk, reset            : clock, async active-high reset
//   start, num_lines      : run pulse and run length (accepted in IDLE only)
//   busy, done            : run in progress / one-cycle completion pulse
//   in_data/valid/ready   : input line stream
//   op_data, op_valid     : beats issued to the compute pipe
//   result_data           : compute result, valid PIPE_LAT cycles after op_valid
//   out_data/valid/ready  : repacked output line stream (FIFO head)
// Optional macro STREAM_PIPE_STATS_EN adds saturating 64-bit counters
//   stat_lines_in, stat_lines_out, stat_credit_stall, stat_out_stall.
module line_lane_stream_pipe
  import stream_pipe_pkg::*;
#(
  parameter int LINE_W    = LINE_W_DEF,
  parameter int BEAT_W    = 64,
  parameter int PIPE_LAT  = 4,
  parameter int OUT_LINES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       num_lines,
  output logic              busy,
  output logic              done,
  input  logic [LINE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BEAT_W-1:0] op_data,
  output logic              op_valid,
  input  logic [BEAT_W-1:0] result_data,
  output logic [LINE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef STREAM_PIPE_STATS_EN
  ,
  output logic [63:0]       stat_lines_in,
  output logic [63:0]       stat_lines_out,
  output logic [63:0]       stat_credit_stall,
  output logic [63:0]       stat_out_stall
`endif
);
  localparam int BEATS  = LINE_W / BEAT_W;
  localparam int IDX_W  = beat_idx_w(BEATS);
  localparam int CRED_W = credit_w(OUT_LINES, BEATS);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(OUT_LINES * BEATS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BEATS - 1);

  t_state                       state_q, state_d;
  logic [31:0]                  num_len, lines_in, lines_out;
  logic [BEATS-1:0][BEAT_W-1:0] ubuf, pbuf, pack_line;
  logic [IDX_W-1:0]             uidx, pidx;
  logic                         ufull;
  logic [CRED_W-1:0]            credit;
  logic [PIPE_LAT:0]            vld_pipe;
  logic start_acc, in_hs, issue, last_issue, res_vld, push, pop;
  logic fifo_full, fifo_empty;

  assign start_acc  = start && (state_q == IDLE);
  assign issue      = ufull && (credit != '0);
  assign last_issue = issue && (uidx == LAST_IDX);
  // Reload the unpack register in the same cycle its last beat leaves.
  assign in_ready   = (state_q == RUN) && (lines_in < num_len) && (!ufull || last_issue);
  assign in_hs      = in_valid && in_ready;
  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign done       = (state_q == DONE);
  assign out_valid  = !fifo_empty;
  assign pop        = out_valid && out_ready;

  // ---- run controller ----
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (lines_in == num_len) state_d = DRAIN;
      DRAIN:   if (lines_out == num_len) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      num_len   <= '0;
      lines_in  <= '0;
      lines_out <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        num_len   <= num_lines;
        lines_in  <= '0;
        lines_out <= '0;
      end else begin
        if (in_hs) lines_in  <= lines_in + 32'd1;
        if (pop)   lines_out <= lines_out + 32'd1;
      end
    end
  end

  // ---- unpack and issue (LSB beat first) ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ubuf    <= '0;
      uidx    <= '0;
      ufull   <= 1'b0;
      op_data <= '0;
    end else begin
      if (issue) op_data <= ubuf[uidx];
      if (in_hs) begin
        ubuf  <= in_data;
        uidx  <= '0;
        ufull <= 1'b1;
      end else if (issue) begin
        uidx <= last_issue ? '0 : uidx + 1'b1;
        if (last_issue) ufull <= 1'b0;
      end
    end
  end

  // Each credit is one beat of FIFO space, so results can never overflow it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) credit <= CRED_MAX;
    else       credit <= credit + (pop ? CRED_W'(BEATS) : CRED_W'(0))
                                - (issue ? CRED_W'(1) : CRED_W'(0));
  end

  // vld_pipe[0] is op_valid itself; vld_pipe[PIPE_LAT] marks result_data valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[PIPE_LAT-1:0], issue};
  end

  assign op_valid = vld_pipe[0];
  assign res_vld  = vld_pipe[PIPE_LAT];

  // ---- repack; the completing beat is merged straight into the push ----
  always_comb begin
    pack_line       = pbuf;
    pack_line[pidx] = result_data;
  end

  assign push = res_vld && (pidx == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pbuf <= '0;
      pidx <= '0;
    end else if (res_vld) begin
      pbuf <= pack_line;
      pidx <= push ? '0 : pidx + 1'b1;
    end
  end

  line_sync_fifo #(.W(LINE_W), .DEPTH(OUT_LINES)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (pack_line),
    .pop   (pop),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset && push) assert (!fifo_full);
  end

`ifdef STREAM_PIPE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_lines_in     <= '0;
      stat_lines_out    <= '0;
      stat_credit_stall <= '0;
      stat_out_stall    <= '0;
    end else if (start_acc) begin
      stat_lines_in     <= '0;
      stat_lines_out    <= '0;
      stat_credit_stall <= '0;
      stat_out_stall    <= '0;
    end else begin
      if (in_hs && !(&stat_lines_in))  stat_lines_in  <= stat_lines_in + 64'd1;
      if (pop && !(&stat_lines_out))   stat_lines_out <= stat_lines_out + 64'd1;
      if (ufull && (credit == '0) && !(&stat_credit_stall))
        stat_credit_stall <= stat_credit_stall + 64'd1;
      if (out_valid && !out_ready && !(&stat_out_stall))
        stat_out_stall <= stat_out_stall + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_line_lane_stream_pipe.sv
// Directed bench for line_lane_stream_pipe: compute pipe modelled as
// result = op_data ^ A5A5..., PIPE_LAT = 4 cycles.
module tb_line_lane_stream_pipe;
  localparam int LINE_W = 512, BEAT_W = 64, PIPE_LAT = 4, OUT_LINES = 4;
  localparam int BEATS = LINE_W / BEAT_W;
  localparam logic [BEAT_W-1:0] PAT = 64'hA5A5_A5A5_A5A5_A5A5;

  logic              clk, reset, start, busy, done;
  logic [31:0]       num_lines;
  logic [LINE_W-1:0] in_data, out_data;
  logic              in_valid, in_ready, op_valid, out_valid, out_ready;
  logic [BEAT_W-1:0] op_data, result_data;

  line_lane_stream_pipe #(.LINE_W(LINE_W), .BEAT_W(BEAT_W), .PIPE_LAT(PIPE_LAT),
                          .OUT_LINES(OUT_LINES)) dut (
    .clk(clk), .reset(reset), .start(start), .num_lines(num_lines),
    .busy(busy), .done(done), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .op_data(op_data), .op_valid(op_valid),
    .result_data(result_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compute pipe model
  logic [BEAT_W-1:0] pipe [PIPE_LAT];
  always @(posedge clk) begin
    pipe[0] <= op_data;
    for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign result_data = pipe[PIPE_LAT-1] ^ PAT;

  // Monitor (sole writer of these)
  int cyc = 0, op_cnt = 0, done_cnt = 0;
  int op_cyc_q[$];
  logic [LINE_W-1:0] got_q[$];
  always @(negedge clk) begin
    cyc++;
    if (reset === 1'b0) begin
      if (op_valid === 1'b1) begin op_cnt++; op_cyc_q.push_back(cyc); end
      if (done === 1'b1) done_cnt++;
      if (out_valid === 1'b1 && out_ready === 1'b1) got_q.push_back(out_data);
    end
  end

  // Input driver: main writes feed_mem/feed_lim, driver owns feed_idx
  logic [LINE_W-1:0] feed_mem [int];
  int feed_lim = 0, feed_idx;
  bit hs_pend;
  initial begin
    in_valid = 1'b0; in_data = '0; feed_idx = 0;
    forever begin
      @(negedge clk);
      hs_pend = (in_valid === 1'b1) && (in_ready === 1'b1);
      @(posedge clk); #1;
      if (hs_pend && reset === 1'b0) feed_idx++;
      if (feed_idx < feed_lim) begin in_valid = 1'b1; in_data = feed_mem[feed_idx]; end
      else in_valid = 1'b0;
    end
  end

  int errors = 0, checks = 0;

  task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] mk_line(input int tag);
    logic [LINE_W-1:0] l;
    for (int k = 0; k < BEATS; k++) l[k*BEAT_W +: BEAT_W] = {32'(tag), 32'(k + 1)};
    return l;
  endfunction

  function automatic logic [LINE_W-1:0] exp_line(input int tag);
    logic [LINE_W-1:0] l;
    l = mk_line(tag);
    for (int k = 0; k < BEATS; k++) l[k*BEAT_W +: BEAT_W] = l[k*BEAT_W +: BEAT_W] ^ PAT;
    return l;
  endfunction

  task automatic tick();   @(posedge clk); #1; endtask
  task automatic sample(); @(negedge clk); #1; endtask

  task automatic push_lines(input int n, input int tag0);
    for (int i = 0; i < n; i++) begin feed_mem[feed_lim] = mk_line(tag0 + i); feed_lim++; end
  endtask

  task automatic do_start(input int n);
    tick(); start = 1'b1; num_lines = n;
    tick(); start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    logic prev_busy;
    prev_busy = busy;
    sample();
    while (done !== 1'b1 && n < budget) begin prev_busy = busy; sample(); n++; end
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy_at_done"}, busy, 1'b0);
    check({tag, "_busy_before_done"}, prev_busy, 1'b1);
  endtask

  task automatic check_lines(input string tag, input int base, input int n, input int tag0);
    check({tag, "_line_count"}, got_q.size() - base, n);
    for (int i = 0; i < n && base + i < got_q.size(); i++)
      check($sformatf("%s_line%0d", tag, i), got_q[base + i], exp_line(tag0 + i));
  endtask

  initial begin
    int gb, ob, db, n;
    start = 1'b0; num_lines = '0; out_ready = 1'b0; reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    check("rst_busy", busy, 0);       check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 0); check("rst_op_valid", op_valid, 0);
    check("rst_out_valid", out_valid, 0); check("rst_op_data", op_data, 0);
    tick(); tick(); reset = 1'b0;

    // Basic: one line
    out_ready = 1'b1; gb = got_q.size(); db = done_cnt;
    push_lines(1, 0);
    do_start(1);
    wait_done("basic", 200);
    repeat (5) sample();
    check_lines("basic", gb, 1, 0);
    check("basic_done_pulses", done_cnt - db, 1);

    // Streaming: 16 lines, no issue gaps
    gb = got_q.size(); ob = op_cyc_q.size();
    push_lines(16, 'h100);
    do_start(16);
    wait_done("stream", 800);
    check("stream_ops", op_cyc_q.size() - ob, 16 * BEATS);
    if (op_cyc_q.size() - ob >= 16 * BEATS)
      check("stream_no_gaps", op_cyc_q[ob + 16*BEATS - 1] - op_cyc_q[ob], 16 * BEATS - 1);
    check_lines("stream", gb, 16, 'h100);

    // Backpressure: credit limits issue to the FIFO capacity
    out_ready = 1'b0; gb = got_q.size(); ob = op_cnt;
    push_lines(8, 'h200);
    do_start(8);
    repeat (100) sample();
    check("bp_ops_stalled", op_cnt - ob, OUT_LINES * BEATS);
    check("bp_op_valid_low", op_valid, 0);
    check("bp_out_valid", out_valid, 1);
    tick(); out_ready = 1'b1;
    wait_done("bp", 800);
    check("bp_ops_total", op_cnt - ob, 8 * BEATS);
    check_lines("bp", gb, 8, 'h200);

    // Zero length
    ob = op_cnt; db = done_cnt;
    tick(); start = 1'b1; num_lines = 0;
    sample(); check("zl_c0_busy", busy, 0); check("zl_c0_done", done, 0);
    tick(); start = 1'b0;
    sample(); check("zl_c1_busy", busy, 1); check("zl_c1_in_ready", in_ready, 0);
              check("zl_c1_done", done, 0);
    sample(); check("zl_c2_done", done, 0); check("zl_c2_in_ready", in_ready, 0);
    sample(); check("zl_c3_done", done, 1); check("zl_c3_busy", busy, 0);
    sample(); check("zl_c4_done", done, 0);
    check("zl_no_ops", op_cnt - ob, 0);
    check("zl_done_pulses", done_cnt - db, 1);

    // Reset mid-run, then a fresh short run
    out_ready = 1'b1; ob = op_cnt;
    push_lines(8, 'h300);
    do_start(8);
    n = 0;
    while (op_cnt - ob < 2 * BEATS + 4 && n < 300) begin sample(); n++; end
    check("mr_reached_line3", op_cnt - ob >= 2 * BEATS + 4, 1'b1);
    @(negedge clk); #2;
    db = done_cnt;
    reset = 1'b1;
    feed_lim = feed_idx;
    #1;
    check("mr_busy", busy, 0);           check("mr_done", done, 0);
    check("mr_in_ready", in_ready, 0);   check("mr_op_valid", op_valid, 0);
    check("mr_out_valid", out_valid, 0); check("mr_op_data", op_data, 0);
    tick(); tick(); reset = 1'b0;
    repeat (3) sample();
    check("mr_no_done", done_cnt - db, 0);
    check("mr_idle", busy, 0);
    gb = got_q.size();
    push_lines(2, 'h400);
    do_start(2);
    wait_done("mr_rerun", 300);
    repeat (3) sample();
    check_lines("mr_rerun", gb, 2, 'h400);

    // Start ignored while busy
    gb = got_q.size(); db = done_cnt;
    push_lines(2, 'h500);
    do_start(2);
    repeat (3) sample();
    check("si_busy", busy, 1);
    tick(); start = 1'b1; num_lines = 5;
    tick(); start = 1'b0;
    wait_done("si", 300);
    repeat (10) sample();
    check("si_done_pulses", done_cnt - db, 1);
    check("si_idle", busy, 0);
    check("si_in_ready", in_ready, 0);
    check_lines("si", gb, 2, 'h500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
